// File: rtl/nand_flash_array.sv
// NAND flash array model: block erase, page program, page read and status over a
// shared tri-state bus, with ready/busy, AND-only programming and a sticky fail flag.
module nand_flash_array #(
   parameter int DIOWidth      = 16,
   parameter int PageWords     = 2048,
   parameter int NumPages      = 64,
   parameter int PagesPerBlock = 8,
   parameter int ProgCycles    = 16,
   parameter int ReadCycles    = 8
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic                cEn,
   input  logic                CLE,
   input  logic                ALE,
   input  logic                wEn,
   input  logic                rEn,
   inout  wire  [DIOWidth-1:0] DIO,
   output logic                rdyBusyN,
   output logic                statusFail
);
   localparam int COL_W    = $clog2(PageWords);
   localparam int PAGE_W   = $clog2(NumPages);
   localparam int BUSY_MAX = (ProgCycles > ReadCycles) ? ProgCycles : ReadCycles;
   localparam int CNT_W    = $clog2(BUSY_MAX + 1);
   localparam logic [DIOWidth-1:0] BLK_MASK   = DIOWidth'(PagesPerBlock - 1);
   localparam logic [DIOWidth-1:0] PAGE_LIMIT = DIOWidth'(NumPages);
   localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(PageWords - 1);
   localparam logic [7:0] OP_ERASE  = 8'h00;
   localparam logic [7:0] OP_PROG   = 8'h40;
   localparam logic [7:0] OP_READ   = 8'h30;
   localparam logic [7:0] OP_STATUS = 8'h70;

   typedef enum logic [2:0] {
      IDLE, ADDR, PROG_DATA, PROG_BUSY, ERASE_BUSY, READ_BUSY, READ_DATA, STATUS
   } state_t;

   state_t                  state_reg;
   logic [DIOWidth-1:0]     page_reg;
   logic [COL_W-1:0]        col_reg;
   logic [CNT_W-1:0]        busy_cnt_reg;
   logic                    rdy_reg;
   logic                    fail_reg;
   logic [DIOWidth-1:0]     rd_word_reg;
   logic [DIOWidth-1:0]     mem [NumPages*PageWords];

   logic                    opcode_cyc;
   logic                    advance;
   logic                    col_last;
   logic                    mem_we;
   logic [COL_W-1:0]        col_next;
   logic [PAGE_W+COL_W-1:0] wr_addr;
   logic [PAGE_W+COL_W-1:0] rd_addr;
   logic [DIOWidth-1:0]     mem_wdata;
   logic [DIOWidth-1:0]     dio_out;
   logic                    dio_oe;

   always_comb begin
      opcode_cyc = cEn && ALE && !CLE && (state_reg == ADDR);
      advance    = (state_reg == ERASE_BUSY)
                || (cEn && wEn && (state_reg == PROG_DATA))
                || (cEn && rEn && (state_reg == READ_DATA));
      col_last   = (col_reg == COL_LAST);
      if (opcode_cyc)
         col_next = '0;
      else if (advance)
         col_next = col_last ? '0 : col_reg + 1'b1;
      else
         col_next = col_reg;
      mem_we    = (state_reg == ERASE_BUSY) || (cEn && wEn && (state_reg == PROG_DATA));
      mem_wdata = (state_reg == ERASE_BUSY) ? '1 : (rd_word_reg & DIO);
      wr_addr   = {page_reg[PAGE_W-1:0], col_reg};
      // Reading at the next column keeps rd_word_reg equal to the word under the column
      // counter, which serves both the read strobe and the program overwrite check.
      rd_addr   = {page_reg[PAGE_W-1:0], col_next};
      dio_oe    = cEn && rEn && ((state_reg == READ_DATA) || (state_reg == STATUS));
      dio_out   = (state_reg == STATUS) ? {{(DIOWidth-2){1'b0}}, rdy_reg, fail_reg} : rd_word_reg;
   end

   assign DIO        = dio_oe ? dio_out : 'z;
   assign rdyBusyN   = rdy_reg;
   assign statusFail = fail_reg;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_addr] <= mem_wdata;
      rd_word_reg <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg    <= IDLE;
         page_reg     <= '0;
         col_reg      <= '0;
         busy_cnt_reg <= '0;
         rdy_reg      <= 1'b1;
         fail_reg     <= 1'b0;
      end else begin
         col_reg <= col_next;
         case (state_reg)
            IDLE, ADDR: begin
               if (cEn && CLE && ALE) begin
                  fail_reg <= 1'b1;
               end else if (cEn && CLE) begin
                  page_reg  <= DIO;
                  state_reg <= ADDR;
               end else if (opcode_cyc) begin
                  if (page_reg >= PAGE_LIMIT) begin
                     fail_reg  <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     case (DIO[7:0])
                        OP_ERASE: begin
                           fail_reg  <= 1'b0;
                           rdy_reg   <= 1'b0;
                           page_reg  <= page_reg & ~BLK_MASK;
                           state_reg <= ERASE_BUSY;
                        end
                        OP_PROG: begin
                           fail_reg  <= 1'b0;
                           state_reg <= PROG_DATA;
                        end
                        OP_READ: begin
                           fail_reg     <= 1'b0;
                           rdy_reg      <= 1'b0;
                           busy_cnt_reg <= CNT_W'(ReadCycles - 1);
                           state_reg    <= READ_BUSY;
                        end
                        OP_STATUS: state_reg <= STATUS;
                        default: begin
                           fail_reg  <= 1'b1;
                           state_reg <= IDLE;
                        end
                     endcase
                  end
               end
            end
            PROG_DATA: begin
               if (!cEn) begin
                  state_reg <= IDLE;
               end else if (wEn) begin
                  if (|(DIO & ~rd_word_reg))
                     fail_reg <= 1'b1;
                  if (col_last) begin
                     rdy_reg      <= 1'b0;
                     busy_cnt_reg <= CNT_W'(ProgCycles - 1);
                     state_reg    <= PROG_BUSY;
                  end
               end
            end
            PROG_BUSY, READ_BUSY: begin
               if (busy_cnt_reg == '0) begin
                  rdy_reg   <= 1'b1;
                  state_reg <= (state_reg == READ_BUSY) ? READ_DATA : IDLE;
               end else begin
                  busy_cnt_reg <= busy_cnt_reg - 1'b1;
               end
            end
            ERASE_BUSY: begin
               // Page register walks the block; column counter walks each page.
               if (col_last) begin
                  if ((page_reg & BLK_MASK) == BLK_MASK) begin
                     rdy_reg   <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     page_reg <= page_reg + 1'b1;
                  end
               end
            end
            READ_DATA: begin
               if (!cEn || (rEn && col_last))
                  state_reg <= IDLE;
            end
            STATUS: begin
               if (!cEn || rEn)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nand_flash_array.sv
// Randomised scoreboard bench for nand_flash_array: a flat-array model predicts every
// read word and status flag; a negedge monitor compares whatever the array drives.
module tb_nand_flash_array;
   localparam int PW  = 2048;
   localparam int NP  = 64;
   localparam int PPB = 8;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic cEn = 1'b0, CLE = 1'b0, ALE = 1'b0, wEn = 1'b0, rEn = 1'b0;
   logic tb_oe = 1'b0;
   logic [15:0] tb_dio = 16'h0;
   wire  [15:0] dio;
   wire         rdy_busy_n;
   wire         status_fail;

   assign dio = tb_oe ? tb_dio : 'z;

   nand_flash_array #(
      .DIOWidth(16), .PageWords(PW), .NumPages(NP), .PagesPerBlock(PPB),
      .ProgCycles(16), .ReadCycles(8)
   ) dut (
      .clk(clk), .rstN(rstN), .cEn(cEn), .CLE(CLE), .ALE(ALE), .wEn(wEn), .rEn(rEn),
      .DIO(dio), .rdyBusyN(rdy_busy_n), .statusFail(status_fail)
   );

   always #5 clk = ~clk;

   logic [15:0] model_mem [NP*PW];
   logic [15:0] pdata [PW];
   logic [15:0] exp_q [$];
   logic        model_fail = 1'b0;
   int          checks = 0;
   int          fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle the array drives the bus must match the next queued word.
   always @(negedge clk) begin
      if (rstN && dut.dio_oe) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_drive: DIO=0x%04h driven with nothing expected", dio);
         end else begin
            check("dio_word", {16'h0, dio}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic bus(input logic c, cl, al, w, r, input logic [15:0] d);
      cEn = c; CLE = cl; ALE = al; wEn = w; rEn = r;
      tb_oe = c & (cl | al | w);
      tb_dio = d;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic command(input logic [15:0] page, input logic [7:0] op);
      bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, page);
      bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {8'h00, op});
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!rdy_busy_n && n < 20000) begin
         idle();
         n++;
      end
   endtask

   task automatic do_erase(input int p);
      int n;
      int base;
      command(16'(p), 8'h00);
      base = p & ~(PPB - 1);
      for (int i = 0; i < PPB * PW; i++) model_mem[base*PW + i] = 16'hFFFF;
      model_fail = 1'b0;
      wait_ready(n);
      check("erase_busy_cycles", n, PPB * PW);
      check("erase_status_fail", status_fail, model_fail);
      $display("erase block at page %0d: busy %0d cycles", base, n);
   endtask

   task automatic do_program(input int p);
      int n;
      command(16'(p), 8'h40);
      model_fail = 1'b0;
      for (int i = 0; i < PW; i++) begin
         if ((pdata[i] & ~model_mem[p*PW + i]) != 16'h0) model_fail = 1'b1;
         model_mem[p*PW + i] = model_mem[p*PW + i] & pdata[i];
         bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, pdata[i]);
      end
      wait_ready(n);
      check("prog_busy_cycles", n, 16);
      check("prog_status_fail", status_fail, model_fail);
      $display("program page %0d: busy %0d cycles, statusFail=%0b", p, n, status_fail);
   endtask

   task automatic do_read(input int p);
      int n;
      command(16'(p), 8'h30);
      model_fail = 1'b0;
      wait_ready(n);
      check("read_busy_cycles", n, 8);
      for (int i = 0; i < PW; i++) exp_q.push_back(model_mem[p*PW + i]);
      for (int i = 0; i < PW; i++) bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      idle();
      check("read_words_consumed", exp_q.size(), 0);
      check("read_status_fail", status_fail, model_fail);
      exp_q.delete();
      $display("read page %0d: busy %0d cycles", p, n);
   endtask

   task automatic do_status();
      command(16'h0001, 8'h70);
      exp_q.push_back({14'h0, 1'b1, model_fail});
      bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      idle();
      check("status_word_consumed", exp_q.size(), 0);
      exp_q.delete();
      $display("status read: expected 0x%04h", {14'h0, 1'b1, model_fail});
   endtask

   task automatic clear_fail();
      command(16'h0003, 8'h40);
      idle();
      model_fail = 1'b0;
      check("clear_fail", status_fail, 1'b0);
   endtask

   task automatic reset_pulse(input string tag);
      rstN = 1'b0; cEn = 1'b1; rEn = 1'b1; wEn = 1'b0; CLE = 1'b0; ALE = 1'b0; tb_oe = 1'b0;
      #1;
      check({tag, "_rdy"}, rdy_busy_n, 1'b1);
      check({tag, "_fail"}, status_fail, 1'b0);
      check({tag, "_dio_released"}, dut.dio_oe, 1'b0);
      @(posedge clk); #1;
      rstN = 1'b1;
      idle();
      model_fail = 1'b0;
      $display("reset pulse: %s", tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rp;
      cEn = 1'b1; rEn = 1'b1;
      @(posedge clk); #1;
      check("reset_rdy", rdy_busy_n, 1'b1);
      check("reset_fail", status_fail, 1'b0);
      check("reset_dio_released", dut.dio_oe, 1'b0);
      @(posedge clk); #1;
      rstN = 1'b1;
      idle();

      do_erase(0);
      do_read(0);

      for (int i = 0; i < PW; i++) pdata[i] = 16'(i);
      do_program(1);
      do_read(1);

      for (int i = 0; i < PW; i++) pdata[i] = 16'hFFFF;
      do_program(1);
      do_status();
      do_read(1);

      clear_fail();
      command(16'd64, 8'h30);
      check("range_rdy_stays_high", rdy_busy_n, 1'b1);
      idle();
      check("range_fail", status_fail, 1'b1);

      clear_fail();
      command(16'h0001, 8'h55);
      idle();
      check("bad_opcode_fail", status_fail, 1'b1);
      check("bad_opcode_rdy", rdy_busy_n, 1'b1);

      clear_fail();
      bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005);
      bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0070);
      idle();
      check("ale_cle_fail", status_fail, 1'b1);
      model_fail = 1'b1;
      bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0070);
      exp_q.push_back(16'h0003);
      bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      idle();
      check("ale_cle_status_consumed", exp_q.size(), 0);
      exp_q.delete();
      reset_pulse("reset_after_fail");

      command(16'h0000, 8'h30);
      idle(); idle(); idle();
      check("busy_before_reset", rdy_busy_n, 1'b0);
      reset_pulse("reset_in_read_busy");

      bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001);
      bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030);
      command(16'h0002, 8'h40);
      for (int i = 0; i < 20; i++) begin
         bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
         check("prog_data_ren_released", dut.dio_oe, 1'b0);
      end
      check("prog_data_rdy", rdy_busy_n, 1'b1);
      for (int i = 0; i < 100; i++) begin
         model_mem[2*PW + i] = model_mem[2*PW + i] & (16'h1000 + 16'(i));
         bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000 + 16'(i));
      end
      reset_pulse("reset_mid_program");
      do_read(2);

      rp = 3 + int'($urandom_range(0, 4));
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < PW; i++) pdata[i] = 16'($urandom);
         do_program(rp);
         do_read(rp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
